// File: rtl/display_pkg.sv
// Shared types and segment patterns for the multiplexed 7-segment display driver.
package display_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} disp_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns for decimal digits 0..9
  localparam logic [6:0] SEG_TABLE [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low segment pattern; non-decimal codes blank the digit.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (bcd <= 4'd9) seg = SEG_TABLE[bcd];
  end

endmodule

// File: rtl/display_driver.sv
// Binary-to-decimal (double-dabble) converter feeding a multiplexed common-anode
// 7-segment display with leading-zero blanking.
module display_driver
  import display_pkg::*;
#(
  parameter int unsigned WORD_W      = 8,
  parameter int unsigned DIGITS      = 3,
  parameter int unsigned REFRESH_DIV = 1000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WORD_W-1:0] display,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              busy
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(WORD_W + 1);
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  disp_state_t       r_state, w_next;
  logic              r_pending;
  logic [WORD_W-1:0] r_last_val, r_bin_sr, w_bin_shift;
  logic [BCD_W-1:0]  r_bcd_sr, r_digits, w_bcd_adj, w_bcd_shift;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [REF_W-1:0]  r_refresh;
  logic [IDX_W-1:0]  r_scan_idx;
  logic [6:0]        r_seg, w_dec_seg;
  logic [DIGITS-1:0] r_an;
  logic [3:0]        w_digit;
  logic              w_blank, w_start, w_busy;

  assign w_start = (display != r_last_val) || r_pending;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    case (r_state)
      IDLE:  if (w_start) w_next = LOAD;
      LOAD:  begin w_next = SHIFT; w_busy = 1'b1; end
      SHIFT: begin
        w_busy = 1'b1;
        if (r_bit_cnt == CNT_W'(1)) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign busy = w_busy;

  always_comb begin
    w_bcd_adj = r_bcd_sr;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r_bcd_sr[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd_sr[4*i +: 4] + 4'd3;
    end
  end

  assign {w_bcd_shift, w_bin_shift} = {w_bcd_adj[BCD_W-2:0], r_bin_sr, 1'b0};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pending  <= 1'b1;
      r_last_val <= '0;
      r_bin_sr   <= '0;
      r_bcd_sr   <= '0;
      r_bit_cnt  <= '0;
      r_digits   <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          r_bin_sr   <= display;
          r_last_val <= display;
          r_bcd_sr   <= '0;
          r_pending  <= 1'b0;
          r_bit_cnt  <= CNT_W'(WORD_W);
        end
        SHIFT: begin
          r_bcd_sr  <= w_bcd_shift;
          r_bin_sr  <= w_bin_shift;
          r_bit_cnt <= r_bit_cnt - 1'b1;
          if (r_bit_cnt == CNT_W'(1)) r_digits <= w_bcd_shift;
        end
        default: ;
      endcase
    end
  end

  assign w_digit = r_digits[4*r_scan_idx +: 4];
  // A digit is blank when it and everything above it is zero
  assign w_blank = (r_scan_idx != '0) && ((r_digits >> (4*r_scan_idx)) == '0);

  seg7_decode u_decode (
    .bcd (w_digit),
    .seg (w_dec_seg)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_refresh  <= '0;
      r_scan_idx <= '0;
      r_an       <= '1;
      r_seg      <= SEG_BLANK;
    end else begin
      if (r_refresh == REF_W'(REFRESH_DIV - 1)) begin
        r_refresh  <= '0;
        r_scan_idx <= (r_scan_idx == IDX_W'(DIGITS - 1)) ? '0 : r_scan_idx + 1'b1;
      end else begin
        r_refresh <= r_refresh + 1'b1;
      end
      r_an  <= ~(DIGITS'(1) << r_scan_idx);
      r_seg <= w_blank ? SEG_BLANK : w_dec_seg;
    end
  end

  assign seg = r_seg;
  assign an  = r_an;

endmodule
